// File: rtl/stack_unit_requester.sv
// Initiator for the stack unit's rdy/ack port: buffers client commands in a small FIFO,
// issues one at a time, and returns each outcome as a one-cycle result strobe.
module stack_unit_requester #(
    parameter int W       = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic         rdy,
    output logic [2:0]   op,
    output logic [W-1:0] datain,
    input  logic         ack,
    input  logic [W-1:0] dataout,
    input  logic         esito,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic         res_esito,
    output logic         res_timeout,
    output logic         busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [2:0]    OP_PUSH  = 3'd0;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e        state_q, state_d;
    logic [AW:0]   wrPtr_q, rdPtr_q;
    logic [2:0]    opMem_q   [DEPTH];
    logic [W-1:0]  dataMem_q [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_q, rdy_d;
    logic [2:0]    op_q, op_d;
    logic [W-1:0]  datain_q, datain_d;
    logic          resValid_q, resValid_d;
    logic [W-1:0]  resData_q, resData_d;
    logic          resEsito_q, resEsito_d;
    logic          resTimeout_q, resTimeout_d;

    logic          empty, full, push, pop, headLegal, timedOut;
    logic [2:0]    headOp;
    logic [W-1:0]  headData;

    // Extra pointer bit distinguishes full from empty; cmd_ready depends only on registers.
    assign empty     = (wrPtr_q == rdPtr_q);
    assign full      = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign push      = cmd_valid && !full;
    assign pop       = (state_q == IDLE) && !empty;
    assign headOp    = opMem_q[rdPtr_q[AW-1:0]];
    assign headData  = dataMem_q[rdPtr_q[AW-1:0]];
    assign headLegal = !headOp[2];
    assign timedOut  = (cnt_q == CNT_LAST);

    always_ff @(posedge clock) begin
        if (push) begin
            opMem_q[wrPtr_q[AW-1:0]]   <= cmd_op;
            dataMem_q[wrPtr_q[AW-1:0]] <= cmd_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            cnt_q        <= '0;
            rdy_q        <= 1'b0;
            op_q         <= '0;
            datain_q     <= '0;
            resValid_q   <= 1'b0;
            resData_q    <= '0;
            resEsito_q   <= 1'b0;
            resTimeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wrPtr_q      <= push ? wrPtr_q + PTR_ONE : wrPtr_q;
            rdPtr_q      <= pop ? rdPtr_q + PTR_ONE : rdPtr_q;
            cnt_q        <= cnt_d;
            rdy_q        <= rdy_d;
            op_q         <= op_d;
            datain_q     <= datain_d;
            resValid_q   <= resValid_d;
            resData_q    <= resData_d;
            resEsito_q   <= resEsito_d;
            resTimeout_q <= resTimeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!empty) state_d = headLegal ? ISSUE : RESP;
            ISSUE:   if (ack || timedOut) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An ack on the same edge as the timeout takes priority over the abort.
    always_comb begin
        cnt_d        = cnt_q;
        rdy_d        = rdy_q;
        op_d         = op_q;
        datain_d     = datain_q;
        resValid_d   = 1'b0;
        resData_d    = resData_q;
        resEsito_d   = resEsito_q;
        resTimeout_d = resTimeout_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (headLegal) begin
                        rdy_d    = 1'b1;
                        op_d     = headOp;
                        datain_d = (headOp == OP_PUSH) ? headData : '0;
                        cnt_d    = '0;
                    end else begin
                        resValid_d   = 1'b1;
                        resData_d    = '0;
                        resEsito_d   = 1'b1;
                        resTimeout_d = 1'b0;
                    end
                end
            end
            ISSUE: begin
                if (ack) begin
                    rdy_d        = 1'b0;
                    resValid_d   = 1'b1;
                    resData_d    = dataout;
                    resEsito_d   = esito;
                    resTimeout_d = 1'b0;
                end else if (timedOut) begin
                    rdy_d        = 1'b0;
                    resValid_d   = 1'b1;
                    resData_d    = '0;
                    resEsito_d   = 1'b1;
                    resTimeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready   = !full;
    assign rdy         = rdy_q;
    assign op          = op_q;
    assign datain      = datain_q;
    assign res_valid   = resValid_q;
    assign res_data    = resData_q;
    assign res_esito   = resEsito_q;
    assign res_timeout = resTimeout_q;
    assign busy        = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_stack_unit_requester.sv
// Directed bench for stack_unit_requester: a behavioural stack-unit stub answers rdy,
// a monitor logs rdy pulses and results, and one initial block walks the scenarios.
module tb_stack_unit_requester;
    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        rdy;
    logic [2:0]  op;
    logic [31:0] datain;
    logic        ack;
    logic [31:0] dataout;
    logic        esito;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_esito;
    logic        res_timeout;
    logic        busy;

    stack_unit_requester #(.W(32), .DEPTH(4), .TIMEOUT(64)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rdy(rdy), .op(op), .datain(datain),
        .ack(ack), .dataout(dataout), .esito(esito),
        .res_valid(res_valid), .res_data(res_data), .res_esito(res_esito),
        .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] data;
        logic        esito;
        logic        tmo;
    } res_t;

    int          assertCount = 0;
    int          failCount   = 0;
    res_t        resQ[$];
    int          rdyLens[$];
    logic [2:0]  pulseOp[$];
    logic [31:0] pulseData[$];
    int          rdyRises    = 0;
    int          curLen      = 0;
    int          stableErr   = 0;
    int          doubleRes   = 0;
    logic        prevRdy     = 1'b0;
    logic        prevResValid = 1'b0;
    logic [2:0]  holdOp      = 3'd0;
    logic [31:0] holdData    = 32'd0;

    int          stubDelay   = 3;
    int          stubCnt     = 0;
    int          noAckPulse  = -1;
    logic [31:0] stk[$];

    // Monitor: records every rdy pulse (length, op, operand) and every result strobe.
    always begin
        @(posedge clock);
        #1;
        if (rdy === 1'b1 && !prevRdy) begin
            rdyRises++;
            pulseOp.push_back(op);
            pulseData.push_back(datain);
            curLen = 1;
        end else if (rdy === 1'b1) begin
            curLen++;
            if (op !== holdOp || datain !== holdData) stableErr++;
        end else if (prevRdy) begin
            rdyLens.push_back(curLen);
        end
        holdOp   = op;
        holdData = datain;
        if (res_valid === 1'b1) begin
            resQ.push_back(res_t'({res_data, res_esito, res_timeout}));
            if (prevResValid) doubleRes++;
        end
        prevRdy      = (rdy === 1'b1);
        prevResValid = (res_valid === 1'b1);
    end

    // Stack-unit stub: acks stubDelay cycles after rdy rises, skipping the pulse numbered noAckPulse.
    always @(negedge clock) begin
        ack     = 1'b0;
        dataout = 32'hDEAD_DEAD;
        esito   = 1'b1;
        if (reset === 1'b1) begin
            stubCnt = 0;
            stk.delete();
        end else if (rdy === 1'b1) begin
            stubCnt++;
            if (stubCnt == stubDelay + 1 && rdyRises != noAckPulse) begin
                ack     = 1'b1;
                esito   = 1'b0;
                dataout = 32'd0;
                case (op)
                    3'd0: if (stk.size() >= 8) esito = 1'b1; else stk.push_back(datain);
                    3'd1: if (stk.size() == 0) esito = 1'b1; else dataout = stk.pop_back();
                    3'd2: if (stk.size() == 0) esito = 1'b1; else dataout = stk[$];
                    3'd3: stk.delete();
                    default: esito = 1'b1;
                endcase
            end
        end else begin
            stubCnt = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] dataIn);
        int guard = 0;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = opIn;
        cmd_data  = dataIn;
        while (cmd_ready !== 1'b1 && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("cmdReadyBeforeAccept", 32'(cmd_ready), 32'd1);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitResults(input int n);
        int guard = 0;
        while (resQ.size() < n && guard < 300) begin
            @(posedge clock);
            #2;
            guard++;
        end
        checkOutput("resultCount", 32'(resQ.size()), 32'(n));
    endtask

    task automatic checkResult(input int idx, input logic [31:0] expData, input logic expEsito, input logic expTmo);
        res_t r;
        r = (idx < resQ.size()) ? resQ[idx] : res_t'({32'hFFFF_FFFF, 1'bx, 1'bx});
        checkOutput($sformatf("res%0d.data", idx), r.data, expData);
        checkOutput($sformatf("res%0d.esito", idx), 32'(r.esito), 32'(expEsito));
        checkOutput($sformatf("res%0d.timeout", idx), 32'(r.tmo), 32'(expTmo));
    endtask

    initial begin
        int guard;
        int base;
        int risesBefore;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 32'd0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst.rdy", 32'(rdy), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst.op", 32'(op), 32'd0);
        checkOutput("rst.datain", datain, 32'd0);
        checkOutput("rst.res_data", res_data, 32'd0);
        checkOutput("rst.res_esito", 32'(res_esito), 32'd0);
        checkOutput("rst.res_timeout", 32'(res_timeout), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single PUSH, ack three cycles after rdy
        $display("[TB] single push");
        stubDelay = 3;
        applyStimulus(3'd0, 32'h0000_00A5);
        checkOutput("t1.rdyLowAtAccept", 32'(rdy), 32'd0);
        checkOutput("t1.busy", 32'(busy), 32'd1);
        @(posedge clock);
        #1;
        checkOutput("t1.rdyRise", 32'(rdy), 32'd1);
        checkOutput("t1.op", 32'(op), 32'd0);
        checkOutput("t1.datain", datain, 32'h0000_00A5);
        waitResults(1);
        checkResult(0, 32'd0, 1'b0, 1'b0);
        checkOutput("t1.rdyLen", 32'(rdyLens[0]), 32'd4);

        // Back-to-back PUSH 1, PUSH 2, POP, POP
        $display("[TB] back-to-back stack ops");
        stubDelay = 0;
        applyStimulus(3'd0, 32'd1);
        applyStimulus(3'd0, 32'd2);
        applyStimulus(3'd1, 32'd0);
        applyStimulus(3'd1, 32'd0);
        waitResults(5);
        checkResult(1, 32'd0, 1'b0, 1'b0);
        checkResult(2, 32'd0, 1'b0, 1'b0);
        checkResult(3, 32'd2, 1'b0, 1'b0);
        checkResult(4, 32'd1, 1'b0, 1'b0);
        checkOutput("t2.rdyRises", 32'(rdyRises), 32'd5);
        for (int i = 1; i <= 4; i++) checkOutput($sformatf("t2.rdyLen%0d", i), 32'(rdyLens[i]), 32'd1);

        // CLEAR, POP on empty, PUSH, TOP, then an illegal opcode
        $display("[TB] error paths");
        stubDelay = 1;
        applyStimulus(3'd3, 32'hDEAD_BEEF);
        applyStimulus(3'd1, 32'd0);
        applyStimulus(3'd0, 32'h77);
        applyStimulus(3'd2, 32'd0);
        applyStimulus(3'd5, 32'h1234);
        waitResults(10);
        checkResult(5, 32'd0, 1'b0, 1'b0);
        checkResult(6, 32'd0, 1'b1, 1'b0);
        checkResult(7, 32'd0, 1'b0, 1'b0);
        checkResult(8, 32'h77, 1'b0, 1'b0);
        checkResult(9, 32'd0, 1'b1, 1'b0);
        checkOutput("t3.clearOp", 32'(pulseOp[5]), 32'd3);
        checkOutput("t3.clearDatainZero", pulseData[5], 32'd0);
        checkOutput("t3.pushDatain", pulseData[7], 32'h77);
        checkOutput("t3.illegalNoRdy", 32'(rdyRises), 32'd9);

        // Timeout on an unanswered POP, then a queued TOP
        $display("[TB] timeout");
        stubDelay  = 2;
        noAckPulse = rdyRises + 1;
        applyStimulus(3'd1, 32'd0);
        applyStimulus(3'd2, 32'd0);
        waitResults(12);
        checkResult(10, 32'd0, 1'b1, 1'b1);
        checkResult(11, 32'h77, 1'b0, 1'b0);
        checkOutput("t4.timeoutLen", 32'(rdyLens[9]), 32'd64);
        checkOutput("t4.nextLen", 32'(rdyLens[10]), 32'd3);
        checkOutput("t4.nextOp", 32'(pulseOp[10]), 32'd2);

        // Full FIFO behind a stalled op, extra command held off
        $display("[TB] fifo full");
        stubDelay = 10;
        applyStimulus(3'd0, 32'h11);
        applyStimulus(3'd0, 32'h22);
        applyStimulus(3'd2, 32'd0);
        applyStimulus(3'd1, 32'd0);
        applyStimulus(3'd1, 32'd0);
        checkOutput("t5.cmdReadyFull", 32'(cmd_ready), 32'd0);
        checkOutput("t5.busy", 32'(busy), 32'd1);
        base = resQ.size();
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_data  = 32'd0;
        guard     = 0;
        while (cmd_ready !== 1'b1 && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("t5.heldCycles", 32'(guard >= 1), 32'd1);
        checkOutput("t5.firstDoneBeforeAccept", 32'(resQ.size() > base), 32'd1);
        checkOutput("t5.readyAgain", 32'(cmd_ready), 32'd1);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        waitResults(18);
        checkResult(12, 32'd0, 1'b0, 1'b0);
        checkResult(13, 32'd0, 1'b0, 1'b0);
        checkResult(14, 32'h22, 1'b0, 1'b0);
        checkResult(15, 32'h22, 1'b0, 1'b0);
        checkResult(16, 32'h11, 1'b0, 1'b0);
        checkResult(17, 32'h77, 1'b0, 1'b0);

        // Reset while an op is outstanding with two commands queued
        $display("[TB] reset mid-operation");
        stubDelay = 30;
        applyStimulus(3'd0, 32'h99);
        applyStimulus(3'd0, 32'h98);
        applyStimulus(3'd1, 32'd0);
        checkOutput("t6.rdyBefore", 32'(rdy), 32'd1);
        checkOutput("t6.busyBefore", 32'(busy), 32'd1);
        risesBefore = rdyRises;
        base        = resQ.size();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("t6.rdy", 32'(rdy), 32'd0);
        checkOutput("t6.busy", 32'(busy), 32'd0);
        checkOutput("t6.cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("t6.res_valid", 32'(res_valid), 32'd0);
        checkOutput("t6.res_data", res_data, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (12) @(posedge clock);
        #2;
        checkOutput("t6.noResult", 32'(resQ.size()), 32'(base));
        checkOutput("t6.noReissue", 32'(rdyRises), 32'(risesBefore));
        checkOutput("t6.busyAfter", 32'(busy), 32'd0);

        checkOutput("rdyStable", 32'(stableErr), 32'd0);
        checkOutput("resOneCycle", 32'(doubleRes), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
